// File: rtl/intr_pkg.sv
// Shared types and constants for the 4-source interrupt priority arbiter.
package intr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK  = 2'd2
   } state_e;

   localparam logic [2:0] CFG_PRIO0 = 3'd0;
   localparam logic [2:0] CFG_PRIO1 = 3'd1;
   localparam logic [2:0] CFG_PRIO2 = 3'd2;
   localparam logic [2:0] CFG_PRIO3 = 3'd3;
   localparam logic [2:0] CFG_MASK  = 3'd4;

   localparam int RST_PRIO0 = 1;
   localparam int RST_PRIO1 = 2;
   localparam int RST_PRIO2 = 3;
   localparam int RST_PRIO3 = 4;

endpackage

// File: rtl/intr_prio_select.sv
// Max-priority finder over 4 sources; the lower index wins on a tie.
module intr_prio_select #(
   parameter int PRIO_W = 4
) (
   input  logic [3:0]             valid_i,
   input  logic [3:0][PRIO_W-1:0] prio_i,
   output logic                   found_o,
   output logic [1:0]             idx_o,
   output logic [PRIO_W-1:0]      level_o
);

   logic              found;
   logic [1:0]        idx;
   logic [PRIO_W-1:0] level;

   always_comb begin
      found = 1'b0;
      idx   = 2'd0;
      level = '0;
      // Strict compare keeps the earlier (lower) index on equal priority.
      for (int i = 0; i < 4; i++) begin
         if (valid_i[i] && (!found || prio_i[i] > level)) begin
            found = 1'b1;
            idx   = 2'(i);
            level = prio_i[i];
         end
      end
   end

   assign found_o = found;
   assign idx_o   = idx;
   assign level_o = level;

endmodule

// File: rtl/intr_priority_arbiter.sv
// Interrupt priority arbiter: masks, prioritises and nests 4 sources,
// running the IRQ/IACK handshake towards the CPU.
module intr_priority_arbiter #(
   parameter int PRIO_W = 4,
   parameter int NSRC   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NSRC-1:0]   req,
   input  logic              iack,
   input  logic              eoi,
   input  logic              cfg_we,
   input  logic [2:0]        cfg_addr,
   input  logic [PRIO_W-1:0] cfg_wdata,
   output logic              irq,
   output logic [1:0]        priority_select,
   output logic [NSRC-1:0]   in_service,
   output logic [PRIO_W-1:0] cur_level
);

   import intr_pkg::*;

   state_e                       state_q;
   logic                         irq_q;
   logic [1:0]                   sel_q;
   logic [NSRC-1:0]              svc_q, svc_d;
   logic [PRIO_W-1:0]            cur_q, cur_d;
   logic [NSRC-1:0][PRIO_W-1:0]  prio_q, prio_d;
   logic [NSRC-1:0]              mask_q, mask_d;

   logic [NSRC-1:0]   qual;
   logic              cand_found;
   logic [1:0]        cand_idx;
   logic [PRIO_W-1:0] cand_level;
   logic              svc_found;
   logic [1:0]        svc_idx;
   logic [PRIO_W-1:0] svc_level;
   logic [NSRC-1:0]   eoi_clr;
   logic [NSRC-1:0]   ack_set;
   logic              unused_sel;

   always_comb begin
      for (int n = 0; n < NSRC; n++) begin
         qual[n] = req[n] & ~mask_q[n] & (prio_q[n] != '0)
                 & (prio_q[n] > cur_q);
      end
   end

   intr_prio_select #(.PRIO_W(PRIO_W)) u_cand (
      .valid_i (qual),
      .prio_i  (prio_q),
      .found_o (cand_found),
      .idx_o   (cand_idx),
      .level_o (cand_level)
   );

   // eoi retires the lowest-index in-service source at the current level.
   always_comb begin
      logic hit;
      hit     = 1'b0;
      eoi_clr = '0;
      if (eoi) begin
         for (int n = 0; n < NSRC; n++) begin
            if (!hit && svc_q[n] && prio_q[n] == cur_q) begin
               eoi_clr[n] = 1'b1;
               hit        = 1'b1;
            end
         end
      end
   end

   always_comb begin
      ack_set = '0;
      if (state_q == REQ && iack) ack_set[sel_q] = 1'b1;
      svc_d = (svc_q & ~eoi_clr) | ack_set;
   end

   intr_prio_select #(.PRIO_W(PRIO_W)) u_svc (
      .valid_i (svc_d),
      .prio_i  (prio_q),
      .found_o (svc_found),
      .idx_o   (svc_idx),
      .level_o (svc_level)
   );

   assign cur_d      = svc_found ? svc_level : '0;
   assign unused_sel = ^{svc_idx, cand_level};

   always_comb begin
      prio_d = prio_q;
      mask_d = mask_q;
      if (cfg_we) begin
         if (cfg_addr < CFG_MASK) prio_d[cfg_addr[1:0]] = cfg_wdata;
         else if (cfg_addr == CFG_MASK) mask_d = cfg_wdata[3:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         irq_q   <= 1'b0;
         sel_q   <= 2'd0;
         svc_q   <= '0;
         cur_q   <= '0;
         mask_q  <= '0;
         prio_q[0] <= PRIO_W'(RST_PRIO0);
         prio_q[1] <= PRIO_W'(RST_PRIO1);
         prio_q[2] <= PRIO_W'(RST_PRIO2);
         prio_q[3] <= PRIO_W'(RST_PRIO3);
      end else begin
         svc_q  <= svc_d;
         cur_q  <= cur_d;
         prio_q <= prio_d;
         mask_q <= mask_d;
         unique case (state_q)
            IDLE: begin
               if (cand_found) begin
                  state_q <= REQ;
                  irq_q   <= 1'b1;
                  sel_q   <= cand_idx;
               end
            end
            REQ: begin
               if (iack) begin
                  state_q <= ACK;
                  irq_q   <= 1'b0;
               end else if (!req[sel_q] || mask_q[sel_q]) begin
                  state_q <= IDLE;
                  irq_q   <= 1'b0;
               end
            end
            ACK: begin
               if (!iack) state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               irq_q   <= 1'b0;
            end
         endcase
      end
   end

   assign irq             = irq_q;
   assign priority_select = sel_q;
   assign in_service      = svc_q;
   assign cur_level       = cur_q;

endmodule

// File: tb/tb_intr_priority_arbiter.sv
// Directed bench for intr_priority_arbiter with hand-computed expectations.
module tb_intr_priority_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       iack;
   logic       eoi;
   logic       cfg_we;
   logic [2:0] cfg_addr;
   logic [3:0] cfg_wdata;
   logic       irq;
   logic [1:0] priority_select;
   logic [3:0] in_service;
   logic [3:0] cur_level;

   int vectors = 0;
   int miscompares = 0;

   intr_priority_arbiter dut (
      .clk             (clk),
      .rst             (rst),
      .req             (req),
      .iack            (iack),
      .eoi             (eoi),
      .cfg_we          (cfg_we),
      .cfg_addr        (cfg_addr),
      .cfg_wdata       (cfg_wdata),
      .irq             (irq),
      .priority_select (priority_select),
      .in_service      (in_service),
      .cur_level       (cur_level)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; iack = 1'b0; eoi = 1'b0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      step();
      rst = 1'b0;
   endtask

   task automatic cfg(input logic [2:0] a, input logic [3:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      step();
      cfg_we = 1'b0;
   endtask

   initial begin
      do_reset();
      chk("rst_irq", 8'(irq), 8'h0);
      chk("rst_sel", 8'(priority_select), 8'h0);
      chk("rst_svc", 8'(in_service), 8'h0);
      chk("rst_cur", 8'(cur_level), 8'h0);

      eoi = 1'b1; step(); eoi = 1'b0;
      chk("eoi_idle_svc", 8'(in_service), 8'h0);

      // basic request/ack
      req = 4'b0101; step();
      chk("basic_irq", 8'(irq), 8'h1);
      chk("basic_sel", 8'(priority_select), 8'h2);
      iack = 1'b1; step();
      chk("basic_ack_svc", 8'(in_service), 8'h4);
      chk("basic_ack_cur", 8'(cur_level), 8'h3);
      chk("basic_ack_irq", 8'(irq), 8'h0);
      chk("basic_ack_sel", 8'(priority_select), 8'h2);
      req = 4'b0001; iack = 1'b0; step();
      step();
      chk("basic_lower_blocked", 8'(irq), 8'h0);
      eoi = 1'b1; step(); eoi = 1'b0;
      chk("basic_eoi_svc", 8'(in_service), 8'h0);
      chk("basic_eoi_cur", 8'(cur_level), 8'h0);
      step();
      chk("basic_src0_irq", 8'(irq), 8'h1);
      chk("basic_src0_sel", 8'(priority_select), 8'h0);
      req = 4'b0000; step();
      chk("basic_withdraw", 8'(irq), 8'h0);

      // tie-break
      do_reset();
      cfg(3'd0, 4'd5);
      cfg(3'd1, 4'd5);
      req = 4'b0011; step();
      chk("tie_irq", 8'(irq), 8'h1);
      chk("tie_sel", 8'(priority_select), 8'h0);

      // nesting
      do_reset();
      req = 4'b0010; step();
      chk("nest_sel1", 8'(priority_select), 8'h1);
      iack = 1'b1; step();
      chk("nest_cur2", 8'(cur_level), 8'h2);
      iack = 1'b0; req = 4'b0000; step();
      req = 4'b0001; step();
      chk("nest_low_blocked", 8'(irq), 8'h0);
      req = 4'b1001; step();
      chk("nest_hi_irq", 8'(irq), 8'h1);
      chk("nest_hi_sel", 8'(priority_select), 8'h3);
      iack = 1'b1; step();
      chk("nest_svc", 8'(in_service), 8'ha);
      chk("nest_cur4", 8'(cur_level), 8'h4);
      iack = 1'b0; req = 4'b0001; step();
      eoi = 1'b1; step(); eoi = 1'b0;
      chk("nest_eoi_svc", 8'(in_service), 8'h2);
      chk("nest_eoi_cur", 8'(cur_level), 8'h2);
      step();
      chk("nest_still_blocked", 8'(irq), 8'h0);

      // withdraw, then withdraw racing iack
      do_reset();
      req = 4'b0100; step();
      chk("wd_req", 8'(irq), 8'h1);
      req = 4'b0000; step();
      chk("wd_irq", 8'(irq), 8'h0);
      step();
      chk("wd_idle", 8'(irq), 8'h0);
      chk("wd_svc", 8'(in_service), 8'h0);
      req = 4'b0100; step();
      chk("wd2_req", 8'(irq), 8'h1);
      req = 4'b0000; iack = 1'b1; step();
      chk("wd2_svc", 8'(in_service), 8'h4);
      chk("wd2_irq", 8'(irq), 8'h0);
      iack = 1'b0; step();

      // masking
      do_reset();
      cfg(3'd4, 4'b1000);
      req = 4'b1000; step();
      chk("mask_irq0", 8'(irq), 8'h0);
      step();
      chk("mask_irq1", 8'(irq), 8'h0);
      cfg(3'd4, 4'b0000);
      step();
      chk("unmask_irq", 8'(irq), 8'h1);
      chk("unmask_sel", 8'(priority_select), 8'h3);
      cfg(3'd4, 4'b1000);
      step();
      chk("mask_withdraw", 8'(irq), 8'h0);

      // reset mid-handshake
      do_reset();
      cfg(3'd0, 4'd7);
      req = 4'b0001; step();
      chk("rstack_sel", 8'(priority_select), 8'h0);
      iack = 1'b1; step();
      chk("rstack_svc", 8'(in_service), 8'h1);
      chk("rstack_cur", 8'(cur_level), 8'h7);
      rst = 1'b1; step();
      chk("rstmid_irq", 8'(irq), 8'h0);
      chk("rstmid_sel", 8'(priority_select), 8'h0);
      chk("rstmid_svc", 8'(in_service), 8'h0);
      chk("rstmid_cur", 8'(cur_level), 8'h0);
      rst = 1'b0; iack = 1'b0; req = 4'b0011; step();
      chk("rstmid_prio_irq", 8'(irq), 8'h1);
      chk("rstmid_prio_sel", 8'(priority_select), 8'h1);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
